// File: rtl/axil_arbiter_rr_wr.sv
// AXI-Lite write-channel arbiter: fixed-priority or round-robin grant, held until the B handshake.
// Define ARB_TIMEOUT_EN to build the ACKN-state watchdog that aborts a stalled grant.
module axil_arbiter_rr_wr #(
    parameter int unsigned NUMBER_MASTER  = 4,
    parameter int unsigned ARB_MODE       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUMBER_MASTER-1:0]         request_wr,
    output logic [NUMBER_MASTER-1:0]         grant_wr,
    output logic [$clog2(NUMBER_MASTER)-1:0] grant_wr_cdr,
    output logic                             grant_valid,
    input  logic                             s_axil_bvalid,
    input  logic [NUMBER_MASTER-1:0]         m_axil_bready,
    output logic                             timeout_pulse
);
    localparam int unsigned IDX_W = $clog2(NUMBER_MASTER);

    if (NUMBER_MASTER < 2 || NUMBER_MASTER > 16) begin : g_bad_number_master
        $error("NUMBER_MASTER must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic {StIdle, StAckn} state_e;

    state_e                   state_q, state_d;
    logic [NUMBER_MASTER-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]         cdr_q, cdr_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                     valid_q, valid_d;
    logic [IDX_W-1:0]         winner_idx;
    logic [IDX_W-1:0]         cand_idx;
    int unsigned              cand;
    logic                     complete;
    logic                     abort;

    // Scan from lowest to highest priority so the last hit is the winner; the round-robin
    // search wraps modulo NUMBER_MASTER so non-power-of-two counts never produce a bad index.
    always_comb begin
        winner_idx = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = int'(NUMBER_MASTER) - 1; i >= 0; i--) begin
            if (ARB_MODE == 0) begin
                cand = unsigned'(i);
            end else begin
                cand = (unsigned'(i) + 32'(rr_ptr_q) + 32'd1) % NUMBER_MASTER;
            end
            cand_idx = IDX_W'(cand);
            if (request_wr[cand_idx]) begin
                winner_idx = cand_idx;
            end
        end
    end

    assign complete = s_axil_bvalid && m_axil_bready[cdr_q];

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_q;

    // Completion has priority: a same-cycle completion suppresses the abort.
    assign abort = (state_q == StAckn) && !complete && (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_pulse = abort;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wd_cnt_q <= '0;
        end else if (state_q == StIdle) begin
            wd_cnt_q <= '0;
        end else if (!complete) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end
`else
    assign abort         = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cdr_d    = cdr_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (|request_wr) begin
                    state_d  = StAckn;
                    grant_d  = NUMBER_MASTER'(1) << winner_idx;
                    cdr_d    = winner_idx;
                    valid_d  = 1'b1;
                    rr_ptr_d = winner_idx;
                end
            end
            StAckn: begin
                // rr_ptr is left on the released master, so it has lowest priority next round.
                if (complete || abort) begin
                    state_d = StIdle;
                    grant_d = '0;
                    cdr_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            cdr_q    <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= IDX_W'(NUMBER_MASTER - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cdr_q    <= cdr_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_wr     = grant_q;
    assign grant_wr_cdr = cdr_q;
    assign grant_valid  = valid_q;

endmodule

// File: tb/tb_axil_arbiter_rr_wr.sv
// Self-checking bench for axil_arbiter_rr_wr: fixed/4, round-robin/4 (timeout 8) and round-robin/3
// instances, with expected grant indices queued at stimulus time and popped when a grant appears.
module tb_axil_arbiter_rr_wr;
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [3:0] req_fx = '0, bready_fx = '0, gnt_fx;
    logic       bvalid_fx = 1'b0, gv_fx, to_fx;
    logic [1:0] cdr_fx;

    logic [3:0] req_rr = '0, bready_rr = '0, gnt_rr;
    logic       bvalid_rr = 1'b0, gv_rr, to_rr;
    logic [1:0] cdr_rr;

    logic [2:0] req_r3 = '0, bready_r3 = '0, gnt_r3;
    logic       bvalid_r3 = 1'b0, gv_r3, to_r3;
    logic [1:0] cdr_r3;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_fx[$];
    int exp_rr[$];
    int exp_r3[$];

    axil_arbiter_rr_wr #(.NUMBER_MASTER(4), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut_fx (
        .aclk(aclk), .aresetn(aresetn), .request_wr(req_fx), .grant_wr(gnt_fx),
        .grant_wr_cdr(cdr_fx), .grant_valid(gv_fx), .s_axil_bvalid(bvalid_fx),
        .m_axil_bready(bready_fx), .timeout_pulse(to_fx)
    );

    axil_arbiter_rr_wr #(.NUMBER_MASTER(4), .ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut_rr (
        .aclk(aclk), .aresetn(aresetn), .request_wr(req_rr), .grant_wr(gnt_rr),
        .grant_wr_cdr(cdr_rr), .grant_valid(gv_rr), .s_axil_bvalid(bvalid_rr),
        .m_axil_bready(bready_rr), .timeout_pulse(to_rr)
    );

    axil_arbiter_rr_wr #(.NUMBER_MASTER(3), .ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut_r3 (
        .aclk(aclk), .aresetn(aresetn), .request_wr(req_r3), .grant_wr(gnt_r3),
        .grant_wr_cdr(cdr_r3), .grant_valid(gv_r3), .s_axil_bvalid(bvalid_r3),
        .m_axil_bready(bready_r3), .timeout_pulse(to_r3)
    );

    function automatic logic [22:0] all_outs();
        return {gnt_fx, cdr_fx, gv_fx, to_fx, gnt_rr, cdr_rr, gv_rr, to_rr,
                gnt_r3, cdr_r3, gv_r3, to_r3};
    endfunction

    task automatic test_reset();
        logic [22:0] obs;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        obs = all_outs();
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            obs = all_outs();
            n_tests++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL idle_after_reset[%0d]: got %h want 0", i, obs);
            end
        end
    endtask

    task automatic test_fixed_priority();
        int e;
        @(posedge aclk);
        #1 req_fx = 4'b1010;
        exp_fx.push_back(1);
        @(negedge aclk);
        n_tests++;
        if (gv_fx !== 1'b0) begin
            n_fail++;
            $display("FAIL fx_latency: got gv=%b want 0", gv_fx);
        end
        @(negedge aclk);
        e = exp_fx.pop_front();
        n_tests++;
        if (gnt_fx !== 4'(1 << e) || cdr_fx !== 2'(e) || gv_fx !== 1'b1) begin
            n_fail++;
            $display("FAIL fx_grant_first: got gnt=%b cdr=%0d gv=%b want gnt=%b cdr=%0d gv=1",
                     gnt_fx, cdr_fx, gv_fx, 4'(1 << e), e);
        end
        @(posedge aclk);
        #1 bvalid_fx = 1'b1;
        bready_fx = 4'b0010;
        @(negedge aclk);
        n_tests++;
        if (gv_fx !== 1'b1) begin
            n_fail++;
            $display("FAIL fx_hold_before_b: got gv=%b want 1", gv_fx);
        end
        @(posedge aclk);
        #1 bvalid_fx = 1'b0;
        bready_fx = 4'b0000;
        req_fx = 4'b1000;
        exp_fx.push_back(3);
        @(negedge aclk);
        n_tests++;
        if (gv_fx !== 1'b0 || gnt_fx !== 4'b0000) begin
            n_fail++;
            $display("FAIL fx_release: got gnt=%b gv=%b want 0000/0", gnt_fx, gv_fx);
        end
        @(negedge aclk);
        e = exp_fx.pop_front();
        n_tests++;
        if (gnt_fx !== 4'(1 << e) || cdr_fx !== 2'(e) || gv_fx !== 1'b1) begin
            n_fail++;
            $display("FAIL fx_grant_second: got gnt=%b cdr=%0d want gnt=%b cdr=%0d",
                     gnt_fx, cdr_fx, 4'(1 << e), e);
        end
        @(posedge aclk);
        #1 bvalid_fx = 1'b1;
        bready_fx = 4'b1000;
        @(posedge aclk);
        #1 bvalid_fx = 1'b0;
        bready_fx = 4'b0000;
        req_fx = 4'b0000;
        @(negedge aclk);
        n_tests++;
        if (gv_fx !== 1'b0) begin
            n_fail++;
            $display("FAIL fx_release_second: got gv=%b want 0", gv_fx);
        end
    endtask

    task automatic test_wrong_bready();
        int e;
        @(posedge aclk);
        #1 req_fx = 4'b0100;
        exp_fx.push_back(2);
        @(posedge aclk);
        @(negedge aclk);
        e = exp_fx.pop_front();
        n_tests++;
        if (gnt_fx !== 4'(1 << e) || cdr_fx !== 2'(e)) begin
            n_fail++;
            $display("FAIL wb_grant: got gnt=%b cdr=%0d want gnt=%b cdr=%0d",
                     gnt_fx, cdr_fx, 4'(1 << e), e);
        end
        // Master drops its request while granted; only a matching BREADY may release it.
        @(posedge aclk);
        #1 bvalid_fx = 1'b1;
        bready_fx = 4'b1011;
        req_fx = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk);
            @(negedge aclk);
            n_tests++;
            if (gnt_fx !== 4'b0100 || gv_fx !== 1'b1) begin
                n_fail++;
                $display("FAIL wb_hold[%0d]: got gnt=%b gv=%b want 0100/1", i, gnt_fx, gv_fx);
            end
        end
        bready_fx = 4'b1111;
        @(posedge aclk);
        @(negedge aclk);
        n_tests++;
        if (gnt_fx !== 4'b0000 || gv_fx !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_release: got gnt=%b gv=%b want 0000/0", gnt_fx, gv_fx);
        end
        bvalid_fx = 1'b0;
        bready_fx = 4'b0000;
    endtask

    task automatic test_round_robin();
        int cnt[4];
        int e;
        int waitc;
        cnt = '{0, 0, 0, 0};
        @(posedge aclk);
        #1 req_rr = 4'b1111;
        exp_rr.push_back(0);
        exp_rr.push_back(1);
        exp_rr.push_back(2);
        exp_rr.push_back(3);
        exp_rr.push_back(0);
        for (int k = 0; k < 5; k++) begin
            waitc = 0;
            do begin
                @(negedge aclk);
                waitc++;
            end while (gv_rr !== 1'b1 && waitc < 10);
            e = exp_rr.pop_front();
            n_tests++;
            if (gv_rr !== 1'b1 || cdr_rr !== 2'(e) || gnt_rr !== 4'(1 << e)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got gnt=%b cdr=%0d gv=%b want gnt=%b cdr=%0d",
                         k, gnt_rr, cdr_rr, gv_rr, 4'(1 << e), e);
            end
            if (k < 4 && !$isunknown(cdr_rr)) cnt[cdr_rr]++;
            @(posedge aclk);
            #1 bvalid_rr = 1'b1;
            bready_rr = 4'(1 << e);
            @(posedge aclk);
            #1 bvalid_rr = 1'b0;
            bready_rr = 4'b0000;
            if (k == 4) req_rr = 4'b0000;
            @(negedge aclk);
            n_tests++;
            if (gv_rr !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_release[%0d]: got gv=%b want 0", k, gv_rr);
            end
        end
        for (int m = 0; m < 4; m++) begin
            n_tests++;
            if (cnt[m] != 1) begin
                n_fail++;
                $display("FAIL rr_fairness[%0d]: got %0d grants want 1", m, cnt[m]);
            end
        end
    endtask

    task automatic test_rr_three();
        int e;
        int waitc;
        @(posedge aclk);
        #1 req_r3 = 3'b111;
        exp_r3.push_back(0);
        exp_r3.push_back(1);
        exp_r3.push_back(2);
        exp_r3.push_back(0);
        for (int k = 0; k < 4; k++) begin
            waitc = 0;
            do begin
                @(negedge aclk);
                waitc++;
                n_tests++;
                if (cdr_r3 === 2'd3) begin
                    n_fail++;
                    $display("FAIL r3_cdr_range: got cdr=%0d want <=2", cdr_r3);
                end
            end while (gv_r3 !== 1'b1 && waitc < 10);
            e = exp_r3.pop_front();
            n_tests++;
            if (gv_r3 !== 1'b1 || cdr_r3 !== 2'(e) || gnt_r3 !== 3'(1 << e)) begin
                n_fail++;
                $display("FAIL r3_order[%0d]: got gnt=%b cdr=%0d gv=%b want gnt=%b cdr=%0d",
                         k, gnt_r3, cdr_r3, gv_r3, 3'(1 << e), e);
            end
            @(posedge aclk);
            #1 bvalid_r3 = 1'b1;
            bready_r3 = 3'(1 << e);
            @(posedge aclk);
            #1 bvalid_r3 = 1'b0;
            bready_r3 = 3'b000;
            if (k == 3) req_r3 = 3'b000;
        end
        @(negedge aclk);
        n_tests++;
        if (gv_r3 !== 1'b0) begin
            n_fail++;
            $display("FAIL r3_release: got gv=%b want 0", gv_r3);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int e;
        int pulses = 0;
        @(posedge aclk);
        #1 req_rr = 4'b0010;
        exp_rr.push_back(1);
        @(posedge aclk);
        @(negedge aclk);
        e = exp_rr.pop_front();
        n_tests++;
        if (cdr_rr !== 2'(e) || gv_rr !== 1'b1) begin
            n_fail++;
            $display("FAIL to_grant: got cdr=%0d gv=%b want cdr=%0d gv=1", cdr_rr, gv_rr, e);
        end
        req_rr = 4'b0011;
        exp_rr.push_back(0);
        for (int c = 1; c <= 8; c++) begin
            n_tests++;
            if (to_rr !== (c == 8) || gv_rr !== 1'b1) begin
                n_fail++;
                $display("FAIL to_pulse_cycle[%0d]: got pulse=%b gv=%b want pulse=%b gv=1",
                         c, to_rr, gv_rr, (c == 8));
            end
            if (to_rr === 1'b1) pulses++;
            @(negedge aclk);
        end
        if (to_rr === 1'b1) pulses++;
        n_tests++;
        if (gv_rr !== 1'b0 || pulses != 1) begin
            n_fail++;
            $display("FAIL to_abort: got gv=%b pulses=%0d want gv=0 pulses=1", gv_rr, pulses);
        end
        @(negedge aclk);
        e = exp_rr.pop_front();
        n_tests++;
        if (cdr_rr !== 2'(e) || gv_rr !== 1'b1) begin
            n_fail++;
            $display("FAIL to_rr_next: got cdr=%0d gv=%b want cdr=%0d gv=1", cdr_rr, gv_rr, e);
        end
        // Completion lands on the 8th ACKN cycle: it must win over the watchdog.
        for (int c = 1; c <= 8; c++) begin
            n_tests++;
            if (to_rr !== 1'b0 || gv_rr !== 1'b1) begin
                n_fail++;
                $display("FAIL to_coincide[%0d]: got pulse=%b gv=%b want 0/1", c, to_rr, gv_rr);
            end
            if (c == 7) begin
                @(posedge aclk);
                #1 bvalid_rr = 1'b1;
                bready_rr = 4'b0001;
                req_rr = 4'b0000;
            end
            @(negedge aclk);
        end
        bvalid_rr = 1'b0;
        bready_rr = 4'b0000;
        n_tests++;
        if (gv_rr !== 1'b0 || to_rr !== 1'b0) begin
            n_fail++;
            $display("FAIL to_coincide_release: got gv=%b pulse=%b want 0/0", gv_rr, to_rr);
        end
    endtask
`else
    task automatic test_timeout();
        @(posedge aclk);
        #1 req_rr = 4'b0010;
        @(posedge aclk);
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            n_tests++;
            if (to_rr !== 1'b0 || gv_rr !== 1'b1 || gnt_rr !== 4'b0010) begin
                n_fail++;
                $display("FAIL no_timeout_hold[%0d]: got pulse=%b gv=%b gnt=%b want 0/1/0010",
                         c, to_rr, gv_rr, gnt_rr);
            end
        end
        bvalid_rr = 1'b1;
        bready_rr = 4'b0010;
        req_rr = 4'b0000;
        @(posedge aclk);
        #1 bvalid_rr = 1'b0;
        bready_rr = 4'b0000;
        @(negedge aclk);
        n_tests++;
        if (gv_rr !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_release: got gv=%b want 0", gv_rr);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int e;
        @(posedge aclk);
        #1 req_fx = 4'b0001;
        exp_fx.push_back(0);
        @(posedge aclk);
        @(negedge aclk);
        e = exp_fx.pop_front();
        n_tests++;
        if (gnt_fx !== 4'(1 << e) || gv_fx !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_grant: got gnt=%b gv=%b want %b/1", gnt_fx, gv_fx, 4'(1 << e));
        end
        aresetn = 1'b0;
        req_fx = 4'b0000;
        @(posedge aclk);
        @(negedge aclk);
        n_tests++;
        if (gnt_fx !== 4'b0000 || cdr_fx !== 2'd0 || gv_fx !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got gnt=%b cdr=%0d gv=%b want 0/0/0", gnt_fx, cdr_fx, gv_fx);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        n_tests++;
        if (gv_fx !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after_release: got gv=%b want 0", gv_fx);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_wrong_bready();
        test_round_robin();
        test_rr_three();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/axil_arbiter_rr_wr.md
Name: axil_arbiter_rr_wr

Overview:
- Parametrised write-channel arbiter for the AXI-Lite interconnect.
- Grants one of NUMBER_MASTER masters ownership of the shared AW/W/B path and holds the grant until that master's B handshake completes.
- Selectable fixed-priority or round-robin policy, plus a registered encoded grant index for the interconnect muxes.
- Sits between the master-side request decode and the slave-side AW/W/B multiplexers.

Parameters:
- NUMBER_MASTER, 4, number of requesting masters; legal range 2..16.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 256, watchdog limit in ACKN state; used only when ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- aclk  input  1  clock
- aresetn  input  1  synchronous active-low reset
- request_wr  input  NUMBER_MASTER  per-master write request, level; held by the master until its B handshake
- grant_wr  output  NUMBER_MASTER  one-hot registered grant
- grant_wr_cdr  output  $clog2(NUMBER_MASTER)  registered encoded index of the granted master
- grant_valid  output  1  registered; high while any grant is held
- s_axil_bvalid  input  1  BVALID from the slave side
- m_axil_bready  input  NUMBER_MASTER  per-master BREADY
- timeout_pulse  output  1  one-cycle pulse when the watchdog aborts a grant; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset: aclk, with aresetn synchronous and active-low. Reset values: state = IDLE, grant_wr = 0, grant_wr_cdr = 0, grant_valid = 0, timeout_pulse = 0, rr_ptr = NUMBER_MASTER-1 (so master 0 is searched first), watchdog counter = 0.
- Reset asserted mid-transaction: the grant drops on the next edge and no completion is recorded.
- States: IDLE, ACKN.
- IDLE with |request_wr = 0: stay in IDLE, outputs stay 0.
- IDLE with |request_wr = 1: on the next edge, register the winner into grant_wr, grant_wr_cdr and grant_valid = 1, and go to ACKN. Request-to-grant latency is 1 cycle.
- Winner selection, fixed mode: lowest set index of request_wr.
- Winner selection, round-robin mode: first set index searching rr_ptr+1, rr_ptr+2, … modulo NUMBER_MASTER. rr_ptr is loaded with the winner index at grant time.
- ACKN completion condition: s_axil_bvalid && m_axil_bready[grant_wr_cdr]. Indexing uses the encoded index, not the one-hot vector.
- ACKN on completion: on the next edge, clear grant_wr, grant_wr_cdr and grant_valid, and go to IDLE.
- ACKN otherwise: hold the grant. Requests from other masters are ignored while in ACKN.
- Back-to-back traffic: at least one IDLE cycle separates consecutive grants, giving a 2-cycle minimum grant-to-grant gap.
- Granted master drops its request in ACKN without completing: the grant is still held; only completion, watchdog abort or reset releases it.
- BVALID addressed to a master whose BREADY is low: no completion, grant is held.
- Encoding when NUMBER_MASTER is not a power of two: grant_wr_cdr never exceeds NUMBER_MASTER-1, and the round-robin wrap uses modulo NUMBER_MASTER, not 2^width.
- Invariants: grant_wr is always one-hot or zero. grant_valid == |grant_wr.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined: a 16-bit counter clears on entry to ACKN and increments each ACKN cycle without completion. When it reaches TIMEOUT_CYCLES-1 and completion is still absent:
  - timeout_pulse = 1 for one cycle;
  - the grant is cleared and the state returns to IDLE;
  - in round-robin mode rr_ptr keeps the aborted index, so that master has lowest priority next.
- Completion and timeout in the same cycle: completion wins and timeout_pulse stays 0.
- When undefined: no counter logic is built, timeout_pulse is constant 0, and a grant is held indefinitely.

Test Plan:
- Reset then idle: aresetn low 3 cycles, request_wr = 0 → all outputs 0; after release they stay 0 for 10 cycles.
- Fixed mode, NUMBER_MASTER = 4: request_wr = 4'b1010 → next cycle grant_wr = 4'b0010, cdr = 1. bvalid & bready[1] → grant clears one cycle later. Request 4'b1000 remains → grant 4'b1000 two cycles after the previous completion.
- Round-robin mode: all 4 masters request continuously, each completing 2 cycles after grant → grant order 0,1,2,3,0; every master granted exactly once per 4 grants.
- Wrong-master BREADY: grant on master 2, bvalid = 1, m_axil_bready = 4'b1011 → grant held. bready[2] rises → release on the next edge.
- NUMBER_MASTER = 3, round-robin: requests 3'b111 → cdr sequence 0,1,2,0; cdr never equals 3.
- ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8: grant master 1 and never complete → timeout_pulse high exactly once, on the 8th ACKN cycle, and grant cleared. Next grant with requests 4'b0011 goes to master 0 (round-robin). Completion coinciding with the 8th cycle → no pulse.
